// File: rtl/keypad_pkg_zyq.sv
// keypad_pkg_zyq: shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state encoding, column one-hot drive patterns, keystat
// field positions and two small helpers.
package keypad_pkg_zyq;

  // Scanner FSM states
  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } kp_state_e;

  // Column drive patterns (one-hot, active-low)
  localparam logic [3:0] COL0_DRIVE = 4'b1110;
  localparam logic [3:0] COL1_DRIVE = 4'b1101;
  localparam logic [3:0] COL2_DRIVE = 4'b1011;
  localparam logic [3:0] COL3_DRIVE = 4'b0111;

  // Row pattern with no key pressed (rows are pulled up)
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // keystat field positions
  localparam int KS_WIDTH     = 5;
  localparam int KS_VALID_BIT = 4;
  localparam int KS_CODE_MSB  = 3;
  localparam int KS_CODE_LSB  = 0;

  // Map a column index onto its active-low drive pattern.
  function automatic logic [3:0] col_drive(input logic [1:0] col);
    logic [3:0] drive;
    drive = COL0_DRIVE;
    unique case (col)
      2'd0: drive = COL0_DRIVE;
      2'd1: drive = COL1_DRIVE;
      2'd2: drive = COL2_DRIVE;
      2'd3: drive = COL3_DRIVE;
      default: drive = COL0_DRIVE;
    endcase
    return drive;
  endfunction

  // Index of the lowest-numbered low row; several keys in one column
  // resolve to the smallest row so the code is deterministic.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_zyq.sv
// scan_tick_zyq: free-running prescaler producing a one-cycle tick every
// DIV clock cycles. The counter wraps from DIV-1 to 0 and the tick is
// asserted while the counter holds DIV-1.
module scan_tick_zyq
  import keypad_pkg_zyq::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_MAX);

  // Next count: wrap on the tick cycle, otherwise advance
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan_zyq.sv
// keypad_scan_zyq: 4x4 matrix keypad scanner with debounce.
// Rotates an active-low column drive once per scan tick, freezes on a low
// row, debounces press and release over DEBOUNCE_TICKS ticks and reports
// the key as keystat = {valid, row*4+col} with a one-cycle keypr pulse.
// Optional feature macro: KEY_REPEAT_EN adds auto-repeat pulses every
// REPEAT_TICKS ticks while a key stays held.
module keypad_scan_zyq
  import keypad_pkg_zyq::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 250
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          R,
  output logic [3:0]          C,
  output logic [KS_WIDTH-1:0] keystat,
  output logic                keypr
);

  localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

  // Configurations below 1 make the counters meaningless
  if (SCAN_DIV < 1 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_cfg
    $error("keypad_scan_zyq: SCAN_DIV, DEBOUNCE_TICKS and REPEAT_TICKS must be >= 1");
  end

  // Row synchronizer
  logic [3:0] r_meta_q;
  logic [3:0] r_sync_q;

  // Scanner state
  kp_state_e             state_q, state_d;
  logic [1:0]            col_q, col_d;
  logic [3:0]            row_cap_q, row_cap_d;
  logic [DEB_W-1:0]      deb_cnt_q, deb_cnt_d;
  logic [KS_WIDTH-1:0]   keystat_q, keystat_d;
  logic                  keypr_q, keypr_d;

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
  logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
`endif

  logic tick;
  logic rows_idle;
  logic rows_match;

  scan_tick_zyq #(
    .DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk_i  (CLK),
    .rst_ni (RST),
    .tick   (tick)
  );

  assign rows_idle  = (r_sync_q == ROWS_IDLE);
  assign rows_match = (r_sync_q == row_cap_q);

  // Bring the asynchronous rows into the clock domain (idle level on reset)
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_meta_q <= ROWS_IDLE;
      r_sync_q <= ROWS_IDLE;
    end else begin
      r_meta_q <= R;
      r_sync_q <= r_meta_q;
    end
  end

  // Scan / debounce FSM; all decisions are taken on scan ticks only
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_cap_d = row_cap_q;
    deb_cnt_d = deb_cnt_q;
    keystat_d = keystat_q;
    keypr_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif
    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (!rows_idle) begin
            // Freeze on this column and remember which rows were low
            state_d   = ST_DEB_PRESS;
            row_cap_d = r_sync_q;
            deb_cnt_d = '0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEB_PRESS: begin
          if (!rows_match) begin
            // Pattern changed: treat as bounce and resume scanning
            state_d   = ST_SCAN;
            deb_cnt_d = '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_d   = ST_HELD;
            deb_cnt_d = '0;
            keypr_d   = 1'b1;
            keystat_d[KS_VALID_BIT]            = 1'b1;
            keystat_d[KS_CODE_MSB:KS_CODE_LSB] = {lowest_low_row(row_cap_q), col_q};
`ifdef KEY_REPEAT_EN
            rep_cnt_d = '0;
`endif
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end
        ST_HELD: begin
          // Only the frozen column is driven, so other columns are invisible
          if (rows_idle) begin
            state_d   = ST_DEB_REL;
            deb_cnt_d = '0;
          end
`ifdef KEY_REPEAT_EN
          else if (rep_cnt_q == REP_LAST) begin
            keypr_d   = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
`endif
        end
        ST_DEB_REL: begin
          if (!rows_idle) begin
            // Release bounce: key is still down, no new press reported
            state_d   = ST_HELD;
            deb_cnt_d = '0;
`ifdef KEY_REPEAT_EN
            rep_cnt_d = '0;
`endif
          end else if (deb_cnt_q == DEB_LAST) begin
            // Clean release; the code field keeps the last key
            state_d   = ST_SCAN;
            deb_cnt_d = '0;
            keystat_d[KS_VALID_BIT] = 1'b0;
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end
        default: begin
          state_d   = ST_SCAN;
          deb_cnt_d = '0;
        end
      endcase
    end
  end

  // FSM and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_SCAN;
      col_q     <= 2'd0;
      row_cap_q <= ROWS_IDLE;
      deb_cnt_q <= '0;
      keystat_q <= '0;
      keypr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_cap_q <= row_cap_d;
      deb_cnt_q <= deb_cnt_d;
      keystat_q <= keystat_d;
      keypr_q   <= keypr_d;
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat tick counter, restarted whenever HELD is entered
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  assign C       = col_drive(col_q);
  assign keystat = keystat_q;
  assign keypr   = keypr_q;

endmodule

// File: doc/keypad_scan_zyq.md
KEYPAD_SCAN_ZYQ -- requirements
Module: keypad_scan_zyq

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: CLK cycles per scan tick.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4: consecutive stable scan ticks needed to accept a press or release.
REQ-003 SHALL have parameter REPEAT_TICKS, default 250: scan ticks between auto-repeat pulses (used only when KEY_REPEAT_EN is defined).
REQ-004 SHALL have port CLK, input, 1 bit: single system clock; all state on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port R, input, 4 bits: keypad rows, active-low, externally pulled up, asynchronous to CLK.
REQ-007 SHALL have port C, output, 4 bits: keypad column drive, one-hot active-low.
REQ-008 SHALL have port keystat, output, 5 bits: bit 4 is key-valid, bits 3:0 are the key code.
REQ-009 SHALL have port keypr, output, 1 bit: one-CLK pulse per accepted press (and per repeat, if enabled).

Function
REQ-010 SHALL pass R through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 SHALL derive a one-CLK scan tick every SCAN_DIV cycles from a free-running counter that wraps from SCAN_DIV-1 to 0.
REQ-012 SHALL implement FSM states SCAN, DEB_PRESS, HELD and DEB_REL.
REQ-013 In SCAN, SHALL rotate the active column C0->C1->C2->C3->C0 (C = 1110, 1101, 1011, 0111) on each tick.
REQ-014 In SCAN, on a tick with any synchronized row low, SHALL freeze the column, capture the row pattern and go to DEB_PRESS.
REQ-015 In DEB_PRESS, SHALL count ticks with the row pattern equal to the capture; a mismatch returns to SCAN with the column rotation resuming.
REQ-016 When the count reaches DEBOUNCE_TICKS, SHALL enter HELD, set keystat = {1, row*4+col}, and assert keypr for exactly one CLK.
REQ-017 When several rows are low in the frozen column, SHALL use the lowest-index low row for the code.
REQ-018 Keys pressed in other columns while HELD SHALL be ignored.
REQ-019 In HELD, a tick with all rows high SHALL enter DEB_REL.
REQ-020 In DEB_REL, DEBOUNCE_TICKS consecutive all-high ticks SHALL clear keystat[4] and return to SCAN.
REQ-021 In DEB_REL, any low row SHALL return to HELD without a new keypr.
REQ-022 keystat[3:0] SHALL hold the last code after release; only bit 4 clears.
REQ-023 keypr SHALL be registered; keystat SHALL change on the same CLK edge that asserts keypr.

Reset
REQ-024 Asserting RST low SHALL, asynchronously: set the state to SCAN, C = 1110, keystat = 00000, keypr = 0, and clear all counters and synchronizer flops.
REQ-025 Reset mid-press SHALL abort with no keypr; after release of RST, scanning SHALL restart at column 0.

Configuration
REQ-026 Macro KEY_REPEAT_EN: when defined, while in HELD, keypr SHALL pulse once every REPEAT_TICKS ticks after the initial press pulse; the repeat counter clears on entering HELD.
REQ-027 Without KEY_REPEAT_EN, SHALL produce exactly one keypr per accepted press, and no repeat counter shall exist.

Structure
REQ-028 A shared package keypad_pkg_zyq SHALL hold the FSM state enum, the column one-hot constants and the keystat field positions.
REQ-029 The tick prescaler SHALL be a sub-module scan_tick_zyq (parameter DIV, outputs tick); all other logic stays in keypad_scan_zyq.

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5)
REQ-030 Reset release with no keys -> C cycles 1110, 1101, 1011, 0111 every 4 CLK; keystat=00000 and keypr=0 throughout.
REQ-031 Row1 low while C2 is active, held steady -> exactly one keypr after 3 stable ticks; keystat=1_0110 (code 6).
REQ-032 Row0 bouncing (low 1 tick, high 1 tick) -> no keypr; FSM returns to SCAN.
REQ-033 Hold key 15 (R3/C3), then release with a 1-tick bounce -> one keypr; keystat[4] stays 1 through the bounce and clears 3 ticks after a clean release; keystat[3:0] stays 1111.
REQ-034 Rows 1 and 2 both low in C0 -> code 4; key in C1 pressed while C0 is held -> ignored.
REQ-035 RST pulsed low during DEB_PRESS -> no keypr, outputs at reset values immediately; with KEY_REPEAT_EN, a 12-tick hold -> 3 keypr pulses (press +5 ticks, +10 ticks).
